ps2_key_controller: RTL
=======================

PS2_KEY_CONTROLLER -- requirements
Module: ps2_key_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 8, key-event FIFO depth (power of 2, 2..64).
REQ-002 SHALL have parameter TIMEOUT, default 2_500_000, clk cycles allowed between a prefix byte and the byte that follows it.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port rx_en, output, 1, enable to the PS/2 frame receiver.
REQ-006 SHALL have port rx_done, input, 1, one-cycle pulse: frame complete.
REQ-007 SHALL have port rx_data, input, 8, received byte; valid while rx_done=1.
REQ-008 SHALL have port rx_start, input, 1, start bit of the frame; valid while rx_done=1.
REQ-009 SHALL have port rx_parity, input, 1, parity bit of the frame; valid while rx_done=1.
REQ-010 SHALL have port key_valid, output, 1, FIFO non-empty.
REQ-011 SHALL have port key_ready, input, 1, consumer accepts the head entry.
REQ-012 SHALL have port key_code, output, 10, head entry {ext, brk, code[7:0]}.
REQ-013 SHALL have port ovf, output, 1, sticky overflow flag.
REQ-014 SHALL have port clr_ovf, input, 1, clears ovf.
REQ-015 SHALL have port err_cnt, output, 8, count of rejected frames; saturates at 255.

Function
REQ-016 SHALL drive rx_en=1 when the FIFO is not full; otherwise rx_en=0.
REQ-017 SHALL implement the FSM states IDLE, EXT, BRK, EXT_BRK, PUSH.
REQ-018 In IDLE, an accepted byte SHALL go to: EXT if 0xE0; BRK if 0xF0; otherwise PUSH with ext=0, brk=0.
REQ-019 In EXT, 0xF0 SHALL go to EXT_BRK; 0xE0 SHALL leave the FSM in EXT; any other byte SHALL go to PUSH with ext=1, brk=0.
REQ-020 In BRK and EXT_BRK, any byte other than 0xE0/0xF0 SHALL go to PUSH with brk=1 (ext=1 only from EXT_BRK); a prefix byte SHALL return the FSM to IDLE with nothing pushed.
REQ-021 PUSH SHALL write {ext, brk, code} to the FIFO in one cycle, then return to IDLE; latency is 1 cycle from rx_done to PUSH and 2 cycles to key_valid.
REQ-022 A timeout counter SHALL run in EXT, BRK and EXT_BRK and reset on every accepted byte; on reaching TIMEOUT the FSM SHALL return to IDLE, push nothing and increment err_cnt.
REQ-023 An entry SHALL be popped in any cycle with key_valid=1 and key_ready=1; key_code SHALL always show the head entry.
REQ-024 A push and a pop in the same cycle SHALL both occur, including when the FIFO is full or empty-with-bypass-disabled (an empty FIFO SHALL ignore the pop).
REQ-025 A push to a full FIFO without a simultaneous pop SHALL be dropped and SHALL set ovf; ovf SHALL stay set until clr_ovf=1, and a set event in the same cycle as clr_ovf=1 SHALL win.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a pointer width of log2(DEPTH)+1.

Reset
REQ-027 While rst=1, the block SHALL hold FSM=IDLE, FIFO empty, key_valid=0, key_code=0, ovf=0, err_cnt=0, timeout counter=0 and rx_en=1.
REQ-028 A reset mid-sequence (for example after 0xE0) SHALL discard the partial prefix and all FIFO contents.

Configuration
REQ-029 With PS2_PARITY_CHECK_EN defined, a frame SHALL be accepted only if rx_start=0 and the 9 bits {rx_parity, rx_data} have odd parity; a rejected frame SHALL increment err_cnt and leave the FSM state unchanged.
REQ-030 Without PS2_PARITY_CHECK_EN, every rx_done frame SHALL be accepted, and err_cnt SHALL count only timeouts.

Structure
REQ-031 Package ps2_ctrl_pkg SHALL hold the FSM state enum, the constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0, and the key-event field widths.
REQ-032 The FIFO SHALL be a separate sub-module, ps2_code_fifo (parameters DEPTH and WIDTH=10), instantiated once.

Verification
REQ-033 The bench SHALL cover: byte 0x1C -> key_code=10'h01C, key_valid=1 two cycles after rx_done.
REQ-034 The bench SHALL cover: bytes 0xF0, 0x1C -> a single entry 10'h11C.
REQ-035 The bench SHALL cover: bytes 0xE0, 0xF0, 0x75 -> a single entry 10'h375; and bytes 0xE0, 0x75 -> 10'h275.
REQ-036 The bench SHALL cover, with DEPTH=4 and key_ready=0: 5 make codes -> rx_en=0 after the 4th; the 5th frame is dropped and ovf=1; clr_ovf -> ovf=0.
REQ-037 The bench SHALL cover, with TIMEOUT=100: 0xE0 then idle for 100 cycles -> FSM=IDLE and err_cnt=1; a following 0x75 -> 10'h075.
REQ-038 The bench SHALL cover, with PS2_PARITY_CHECK_EN defined: rx_data=0x1C and rx_parity=1 (even total) -> no entry and err_cnt=1; rx_parity=0 -> entry 10'h01C.

Source files
------------

// File: rtl/ps2_ctrl_pkg.sv
// PS/2 key controller shared definitions.
// FSM state codes, scan-code prefixes and key-event field widths.
package ps2_ctrl_pkg;

    localparam int CODE_W = 8;
    localparam int KEY_W  = CODE_W + 2;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_EXT     = 3'd1;
    localparam state_t S_BRK     = 3'd2;
    localparam state_t S_EXT_BRK = 3'd3;
    localparam state_t S_PUSH    = 3'd4;

endpackage

// File: rtl/ps2_code_fifo.sv
// Key-event FIFO: push/pop in the same cycle, no empty bypass.
// Pointers carry one extra wrap bit to tell full from empty.
module ps2_code_fifo
    import ps2_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = KEY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic             ovf_evt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign ovf_evt = push && full && !do_pop;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; both may move in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into {ext, brk, code}.
// Define PS2_PARITY_CHECK_EN to reject frames with bad start/parity.
module ps2_key_controller
    import ps2_ctrl_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 2_500_000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             rx_en,
    input  logic             rx_done,
    input  logic [7:0]       rx_data,
    input  logic             rx_start,
    input  logic             rx_parity,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [KEY_W-1:0] key_code,
    output logic             ovf,
    input  logic             clr_ovf,
    output logic [7:0]       err_cnt
);

    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

    state_t            state;
    state_t            state_d;
    state_t            base;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] code_d;
    logic              ext_q;
    logic              ext_d;
    logic              brk_q;
    logic              brk_d;
    logic [TW-1:0]     tmo_cnt;
    logic              in_prefix;
    logic              tmo_hit;
    logic              accept;
    logic              rej;
    logic              is_ext;
    logic              is_brk;
    logic              full;
    logic              empty;
    logic              ovf_evt;
    logic [1:0]        err_inc;
    logic [8:0]        err_sum;

`ifdef PS2_PARITY_CHECK_EN
    logic frame_ok;
    assign frame_ok = !rx_start && (^{rx_parity, rx_data});
    assign accept   = rx_done && frame_ok;
    assign rej      = rx_done && !frame_ok;
`else
    logic unused_frame_bits;
    assign unused_frame_bits = ^{rx_start, rx_parity};
    assign accept = rx_done;
    assign rej    = 1'b0;
`endif

    assign is_ext    = (rx_data == PS2_EXT);
    assign is_brk    = (rx_data == PS2_BRK);
    assign in_prefix = (state == S_EXT) || (state == S_BRK) ||
                       (state == S_EXT_BRK);
    assign tmo_hit   = in_prefix && !accept && (tmo_cnt == TMO_MAX);
    assign rx_en     = !full;
    assign key_valid = !empty;
    assign err_inc   = {1'b0, tmo_hit} + {1'b0, rej};
    assign err_sum   = {1'b0, err_cnt} + {7'd0, err_inc};

    // Next-state decode; PUSH behaves as IDLE for a byte arriving with it.
    always_comb begin
        state_d = state;
        code_d  = code_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        base    = (state == S_PUSH) ? S_IDLE : state;
        if (state == S_PUSH) state_d = S_IDLE;
        if (accept) begin
            code_d = rx_data;
            case (base)
                S_EXT: begin
                    unique case (1'b1)
                        is_brk:  state_d = S_EXT_BRK;
                        is_ext:  state_d = S_EXT;
                        default: begin
                            state_d = S_PUSH;
                            ext_d   = 1'b1;
                            brk_d   = 1'b0;
                        end
                    endcase
                end
                S_BRK, S_EXT_BRK: begin
                    if (is_ext || is_brk) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PUSH;
                        ext_d   = (base == S_EXT_BRK);
                        brk_d   = 1'b1;
                    end
                end
                default: begin
                    unique case (1'b1)
                        is_ext:  state_d = S_EXT;
                        is_brk:  state_d = S_BRK;
                        default: begin
                            state_d = S_PUSH;
                            ext_d   = 1'b0;
                            brk_d   = 1'b0;
                        end
                    endcase
                end
            endcase
        end else if (tmo_hit) begin
            state_d = S_IDLE;
        end
    end

    // FSM state and pending key-event register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            code_q <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            state  <= state_d;
            code_q <= code_d;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
        end
    end

    // Prefix timeout counter: restarts on every accepted byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (!in_prefix || accept || tmo_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + TW'(1);
    end

    // Saturating error counter for timeouts and rejected frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // Sticky overflow; a new overflow beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (ovf_evt)
            ovf <= 1'b1;
        else if (clr_ovf)
            ovf <= 1'b0;
    end

    ps2_code_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (state == S_PUSH),
        .push_data ({ext_q, brk_q, code_q}),
        .pop       (key_ready),
        .full      (full),
        .empty     (empty),
        .head      (key_code),
        .ovf_evt   (ovf_evt)
    );

endmodule
